// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int slice_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit stages_divide(input int width, input int stages);
        return (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead slice with group generate/propagate outputs.
module cla_slice
    import cla_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         g,
    output logic         p
);

    logic [W-1:0] gi;
    logic [W-1:0] pi;
    logic [W-1:0] gpre;
    logic [W-1:0] ppre;
    logic [W-1:0] c;

    // Prefix generate/propagate so every carry is a flat function of cin.
    always_comb begin
        gi      = a & b;
        pi      = a ^ b;
        gpre    = '0;
        ppre    = '0;
        c       = '0;
        gpre[0] = gi[0];
        ppre[0] = pi[0];
        for (int i = 1; i < W; i++) begin
            gpre[i] = gi[i] | (pi[i] & gpre[i-1]);
            ppre[i] = pi[i] & ppre[i-1];
        end
        c[0] = cin;
        for (int i = 1; i < W; i++) begin
            c[i] = gpre[i-1] | (ppre[i-1] & cin);
        end
    end

    assign s = pi ^ c;
    assign g = gpre[W-1];
    assign p = ppre[W-1];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor, one SLICE per stage, valid/ready flow control.
// Define CLA_PIPE_FLAGS_EN to build the signed-overflow and zero flag pipeline.
module cla_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SLICE = slice_w(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    if (!stages_divide(WIDTH, STAGES)) begin : g_bad_cfg
        $error("cla_pipe: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];

    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] s_in  [STAGES];
    logic             c_in  [STAGES];
    logic [WIDTH-1:0] s_nx  [STAGES];

    logic [SLICE-1:0] sum_w [STAGES];
    logic             g_w   [STAGES];
    logic             p_w   [STAGES];
    logic             co_w  [STAGES];

    assign adv       = !vld_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign s         = s_q[LAST];
    assign cout      = c_q[LAST];

    // Stage 0 sees the ports (b inverted, carry flipped for subtract); later stages see skew registers.
    always_comb begin
        a_in[0] = a;
        b_in[0] = (sub == OP_ADD) ? b : ~b;
        s_in[0] = '0;
        c_in[0] = ci ^ (sub == OP_SUB);
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            s_in[k] = s_q[k-1];
            c_in[k] = c_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_slice #(.W(SLICE)) u_slice (
            .a   (a_in[k][k*SLICE +: SLICE]),
            .b   (b_in[k][k*SLICE +: SLICE]),
            .cin (c_in[k]),
            .s   (sum_w[k]),
            .g   (g_w[k]),
            .p   (p_w[k])
        );
        assign co_w[k] = g_w[k] | (p_w[k] & c_in[k]);
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nx[k]                  = s_in[k];
            s_nx[k][k*SLICE +: SLICE] = sum_w[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
        end else if (adv) begin
            vld_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_nx[k];
                c_q[k] <= co_w[k];
            end
        end
    end

`ifdef CLA_PIPE_FLAGS_EN
    logic z_q  [STAGES];
    logic z_in [STAGES];
    logic ovf_q;

    always_comb begin
        z_in[0] = 1'b1;
        for (int k = 1; k < STAGES; k++) begin
            z_in[k] = z_q[k-1];
        end
    end

    // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                z_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                z_q[k] <= z_in[k] & ~|sum_w[k];
            end
            ovf_q <= a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1]
                   ^ sum_w[LAST][SLICE-1] ^ co_w[LAST];
        end
    end

    assign zero = z_q[LAST];
    assign ovf  = ovf_q;
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_cla_pipe.sv
// Directed bench for cla_pipe: latency, add/sub corners, stalled stream, async reset, STAGES=1 build.
module tb_cla_pipe;

`ifdef CLA_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;

    logic        in_ready,   out_valid,   cout,   ovf,   zero;
    logic [31:0] s;
    logic        in_ready_1, out_valid_1, cout_1, ovf_1, zero_1;
    logic [31:0] s_1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cla_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    cla_pipe #(.WIDTH(32), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_1),
        .a(a), .b(b), .ci(ci), .sub(sub),
        .out_valid(out_valid_1), .out_ready(out_ready),
        .s(s_1), .cout(cout_1), .ovf(ovf_1), .zero(zero_1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ta, input logic [31:0] tb_v, input logic tci, input logic tsub);
        a   = ta;
        b   = tb_v;
        ci  = tci;
        sub = tsub;
    endtask

    // One isolated beat: accept, confirm no result for 3 edges, then result on the 4th.
    task automatic one_beat(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic tci, input logic tsub, input logic [31:0] es,
                            input logic ec, input logic eo, input logic ez, input bit chk1);
        @(negedge clk);
        drive(ta, tb_v, tci, tsub);
        in_valid = 1'b1;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        if (chk1) begin
            chk({tag, "_s1_valid"}, out_valid_1, 1);
            chk({tag, "_s1_s"}, s_1, es);
            chk({tag, "_s1_cout"}, cout_1, ec);
            chk({tag, "_s1_ovf"}, ovf_1, eo & FLAGS);
            chk({tag, "_s1_zero"}, zero_1, ez & FLAGS);
        end
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_early_valid"}, out_valid, 0);
            @(negedge clk);
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo & FLAGS);
        chk({tag, "_zero"}, zero, ez & FLAGS);
    endtask

    logic [31:0] sa [8];
    logic [31:0] sb [8];
    logic        sci [8];
    logic        ssub [8];
    logic [32:0] exp_r [8];
    logic        exp_o [8];
    logic [31:0] beff;
    logic [31:0] held;
    int          ni, nr, cyc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_s1_out_valid", out_valid_1, 0);
        chk("rst_s1_in_ready", in_ready_1, 1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;

        one_beat("add_wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1);
        one_beat("add_ovf",  32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        one_beat("sub_neg",  32'h5,         32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        one_beat("sub_bin",  32'h7,         32'h5, 1'b1, 1'b1, 32'h1,         1'b1, 1'b0, 1'b0, 1'b0);
        one_beat("sub_eq",   32'h5,         32'h5, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0);
        one_beat("add_ci",   32'h0000_FFFF, 32'h00FF_0001, 1'b1, 1'b0, 32'h0100_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        one_beat("sub_ovf",  32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream with a 3-cycle consumer stall.
        for (int i = 0; i < 8; i++) begin
            sa[i]    = $urandom;
            sb[i]    = $urandom;
            sci[i]   = 1'($urandom_range(0, 1));
            ssub[i]  = 1'(i % 2);
            beff     = ssub[i] ? ~sb[i] : sb[i];
            exp_r[i] = {1'b0, sa[i]} + {1'b0, beff} + {32'h0, sci[i] ^ ssub[i]};
            exp_o[i] = (sa[i][31] == beff[31]) && (exp_r[i][31] != sa[i][31]);
        end
        ni   = 0;
        nr   = 0;
        cyc  = 0;
        held = '0;
        while (nr < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (ni < 8) begin
                drive(sa[ni], sb[ni], sci[ni], ssub[ni]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready) begin
                if (cyc == 6) held = s;
                else chk("stall_s_stable", s, held);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_out_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                chk("stream_s", s, exp_r[nr][31:0]);
                chk("stream_cout", cout, exp_r[nr][32]);
                chk("stream_ovf", ovf, exp_o[nr] & FLAGS);
                chk("stream_zero", zero, (exp_r[nr][31:0] == 32'h0) & FLAGS);
                nr++;
            end
            if (in_valid && in_ready) ni++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_results", nr, 8);
        chk("stream_accepts", ni, 8);

        // Three beats in flight, then asynchronous reset.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h1 + i, 32'h1, 1'b0, 1'b0);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_s", s, 32'h2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_s", s, 0);
        chk("async_rst_cout", cout, 0);
        chk("async_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 0);
        end
        chk("post_rst_in_ready", in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cla_pipe.md
# cla_pipe

Parametrised, pipelined carry-lookahead adder/subtractor for the datapath. WIDTH-bit operands are split into STAGES equal slices. Each pipeline stage resolves one slice with a combinational lookahead slice and registers the carry forward. The block gives one result per cycle at a configurable latency, with valid/ready flow control and optional signed-overflow/zero flags, so the ALU can close timing at wide widths.

## Interface
- WIDTH, 32, operand/result width in bits
- STAGES, 4, pipeline depth; must divide WIDTH; SLICE = WIDTH/STAGES
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat present
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- ci  input  1  carry-in (add) / borrow-in (sub)
- sub  input  1  0 = add, 1 = subtract
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  sum/difference
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  signed overflow
- zero  output  1  s == 0

## Operation
- Add: s = a + b + ci. Sub: s = a + ~b + ~ci, so a − b − ci with borrow-in semantics.
- Accept when in_valid && in_ready at a rising edge.
- Stage k, for k = 0..STAGES−1:
  - adds slice k of a and the effective b, using stage k−1's registered carry (stage 0 uses the effective carry-in);
  - registers the slice sum, the carry out, and the not-yet-consumed upper operand slices (skew registers).
- A per-stage valid bit tracks occupancy.
- Global advance = !out_valid || out_ready; in_ready = advance. When advance is 0, every stage holds, including the input. Bubbles are not collapsed.
- cout is the carry out of the top slice.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- zero accumulates per stage: stage k ANDs the zero-ness of its slice with the incoming zero bit.
- Order is strictly preserved. No beat is dropped or duplicated under any out_ready pattern.
- Reset:
  - all valid bits, s, cout, ovf and zero go to 0 immediately (asynchronous);
  - in_ready is 1 after reset;
  - in-flight beats asserted during reset are discarded.
- STAGES = 1 degenerates to a single registered WIDTH-bit CLA.

## Timing
- Latency: a beat accepted on edge E appears on s/out_valid in the cycle after edge E+STAGES−1 (STAGES edges, accept edge included), provided advance is 1 throughout.
- Throughput: 1 beat/cycle while out_ready = 1.
- out_ready low on the cycle a result is valid: the result holds stable and in_ready falls in the same cycle (combinational from out_ready). Resumes the cycle out_ready returns high.
- in_valid = 0 while advancing inserts a bubble (valid 0), not a hold.
- The critical path is one SLICE-bit lookahead plus carry merge; no path spans more than one slice.

## Configuration
- CLA_PIPE_FLAGS_EN defined: ovf and zero are computed and pipelined as above.
- Not defined: ovf and zero are tied to 0, their pipeline registers are absent, and cout and s are unaffected.

## Structure
- Package cla_pkg holds:
  - the op encoding constants (OP_ADD = 0, OP_SUB = 1);
  - a helper function for SLICE width;
  - the elaboration check that WIDTH % STAGES == 0.
- Sub-module cla_slice: a combinational SLICE-bit carry-lookahead adder with group g/p outputs, instantiated once per stage via generate. Stage carry out = g | (p & cin).
- Top level: operand skew registers, stage valid chain, flag accumulation, handshake.

## Test plan
All scenarios use WIDTH = 32, STAGES = 4 unless stated.
- Add a=0xFFFFFFFF, b=1, ci=0 → s=0, cout=1, zero=1, ovf=0; out_valid exactly 4 edges after accept.
- Add a=0x7FFFFFFF, b=1, ci=0 → s=0x80000000, cout=0, ovf=1, zero=0.
- Sub a=5, b=7, ci=0 → s=0xFFFFFFFE, cout=0, ovf=0. Sub a=7, b=5, ci=1 → s=1, cout=1.
- Stream 8 random beats back-to-back, holding out_ready=0 for 3 cycles mid-stream → in_ready low those cycles, outputs stable, all 8 results in order versus a reference model.
- Assert rst with 3 beats in flight → out_valid=0 immediately (async), no stale results after release, in_ready=1.
- Rebuild without CLA_PIPE_FLAGS_EN and rerun the second scenario → s=0x80000000, cout=0, ovf=0, zero=0. Repeat the first scenario with STAGES=1: latency 1 edge.
